mux_tree_pipe: RTL and testbench

//  Parametrised, pipelined NUM_IN:1 word multiplexer, the successor to the fixed 16:1 single-bit mux trees.
//  - Selects one WIDTH-bit word from NUM_IN packed inputs.
//  - Splits the 2:1 tree into registered stages with a valid/ready handshake.
//  - Used on wide datapaths (register-file read, forwarding select) where a single-cycle 32:1 x 64b tree misses timing.

---
 rtl/mux_tree_pipe.sv | 159 +++++++++++++++
 tb/tb_mux_tree_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN:1 word multiplexer built as a 2:1 tree cut into register stages.
// Each stage resolves LVL_PER_STAGE tree levels. Stages use a valid/ready handshake in which
// bubbles collapse, so an empty stage can load while downstream stages stall.
// Optional build macro MUX_TREE_SEL_CHECK_EN adds the sel_err output. sel_err flags
// sel >= NUM_IN and travels through the pipeline with its word.
module mux_tree_pipe #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned NUM_IN        = 32,
  parameter int unsigned LVL_PER_STAGE = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_IN*WIDTH-1:0]     data_in,
  input  logic [$clog2(NUM_IN)-1:0]   sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            data_out
`ifdef MUX_TREE_SEL_CHECK_EN
  ,
  output logic                        sel_err
`endif
);

  localparam int SelW    = $clog2(NUM_IN);
  localparam int Levels  = SelW;
  localparam int Lat     = (Levels + int'(LVL_PER_STAGE) - 1) / int'(LVL_PER_STAGE);
  localparam int NPad    = 1 << SelW;
  localparam int PadBits = NPad * int'(WIDTH);
  // Intermediate stages only; the last stage register is data_out itself.
  localparam int MidN    = (Lat > 1) ? Lat - 1 : 1;

  typedef logic [NPad-1:0][WIDTH-1:0] tree_t;

  // Pipeline state
  logic [Lat-1:0]             v_q;
  tree_t [MidN-1:0]           data_q;
  logic  [MidN-1:0][SelW-1:0] sel_q;
  logic [WIDTH-1:0]           dout_q;

  // Combinational per-stage signals
  tree_t                      pad_w;
  tree_t [Lat-1:0]            tree_w;
  logic  [Lat-1:0][SelW-1:0]  stg_sel;
  logic [Lat-1:0]             rdy;
  logic [Lat-1:0]             load;
  logic [Lat-1:0]             up_v;

  // Zero-pad the input words up to a power of two; padded slots read back as 0.
  assign pad_w = PadBits'(data_in);

  // Each stage reduces its own slice of tree levels in place, starting from its input array.
  always_comb begin
    tree_w     = '0;
    stg_sel    = '0;
    tree_w[0]  = pad_w;
    stg_sel[0] = sel;
    for (int s = 1; s < Lat; s++) begin
      tree_w[s]  = data_q[s-1];
      stg_sel[s] = sel_q[s-1];
    end
    for (int s = 0; s < Lat; s++) begin
      for (int lv = 0; lv < Levels; lv++) begin
        if (lv / int'(LVL_PER_STAGE) == s) begin
          // sel bit lv = 1 picks the odd word of each pair.
          for (int k = 0; k < NPad / 2; k++) begin
            tree_w[s][k] = stg_sel[s][lv] ? tree_w[s][2*k+1] : tree_w[s][2*k];
          end
        end
      end
    end
  end

  // Ready chain back from the output; a stage loads when it is empty or its word moves on.
  always_comb begin
    rdy         = '0;
    load        = '0;
    up_v        = '0;
    rdy[Lat-1]  = out_ready;
    for (int s = Lat - 2; s >= 0; s--) begin
      rdy[s] = !v_q[s+1] || rdy[s+1];
    end
    up_v[0] = in_valid;
    for (int s = 1; s < Lat; s++) begin
      up_v[s] = v_q[s-1];
    end
    for (int s = 0; s < Lat; s++) begin
      load[s] = !v_q[s] || rdy[s];
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[Lat-1];
  assign data_out  = dout_q;

  // Stage registers: data and sel move only with a valid word, so a drained output holds its
  // last value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q    <= '0;
      data_q <= '0;
      sel_q  <= '0;
      dout_q <= '0;
    end else begin
      for (int s = 0; s < Lat; s++) begin
        if (load[s]) begin
          v_q[s] <= up_v[s];
        end
      end
      for (int s = 0; s < Lat - 1; s++) begin
        if (load[s] && up_v[s]) begin
          data_q[s] <= tree_w[s];
          sel_q[s]  <= stg_sel[s];
        end
      end
      if (load[Lat-1] && up_v[Lat-1]) begin
        dout_q <= tree_w[Lat-1][0];
      end
    end
  end

`ifdef MUX_TREE_SEL_CHECK_EN
  logic           sel_oor;
  logic [Lat-1:0] err_q;
  logic [Lat-1:0] err_up;

  if (NPad == int'(NUM_IN)) begin : g_pow2
    assign sel_oor = 1'b0;
  end else begin : g_npow2
    assign sel_oor = (sel >= SelW'(NUM_IN));
  end

  // Upstream error bit feeding each stage, mirroring the valid chain.
  always_comb begin
    err_up    = '0;
    err_up[0] = sel_oor;
    for (int s = 1; s < Lat; s++) begin
      err_up[s] = err_q[s-1];
    end
  end

  // Range flag rides alongside its word so it lines up with out_valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= '0;
    end else begin
      for (int s = 0; s < Lat; s++) begin
        if (load[s] && up_v[s]) begin
          err_q[s] <= err_up[s];
        end
      end
    end
  end

  assign sel_err = err_q[Lat-1];
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: directed scenarios followed by a randomized run,
// all scored against a queue-based reference of accepted words.
module tb_mux_tree_pipe;

  localparam int W   = 64;
  localparam int N   = 32;
  localparam int N2  = 24;
  localparam int SW  = 5;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            iv;
  logic            ordy;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  din;
  logic            ir;
  logic            ov;
  logic [W-1:0]    dout;

  logic            iv2;
  logic [SW-1:0]   sel2;
  logic [N2*W-1:0] din2;
  logic            ir2;
  logic            ov2;
  logic [W-1:0]    dout2;
`ifdef MUX_TREE_SEL_CHECK_EN
  logic            err1;
  logic            err2;
`endif

  mux_tree_pipe #(.WIDTH(W), .NUM_IN(N), .LVL_PER_STAGE(2)) dut (
    .clk       (clk),
    .reset_n   (rst_n),
    .in_valid  (iv),
    .in_ready  (ir),
    .data_in   (din),
    .sel       (sel),
    .out_valid (ov),
    .out_ready (ordy),
    .data_out  (dout)
`ifdef MUX_TREE_SEL_CHECK_EN
    ,
    .sel_err   (err1)
`endif
  );

  mux_tree_pipe #(.WIDTH(W), .NUM_IN(N2), .LVL_PER_STAGE(2)) dut24 (
    .clk       (clk),
    .reset_n   (rst_n),
    .in_valid  (iv2),
    .in_ready  (ir2),
    .data_in   (din2),
    .sel       (sel2),
    .out_valid (ov2),
    .out_ready (1'b1),
    .data_out  (dout2)
`ifdef MUX_TREE_SEL_CHECK_EN
    ,
    .sel_err   (err2)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: words accepted but not yet delivered, with their accept cycle.
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           acc_n = 0;
  int           got_n = 0;
  logic [W-1:0] last_got = '0;
  int           last_lat = 0;
  bit           chk_lat = 1'b0;
  bit           hold_prev = 1'b0;
  logic [W-1:0] hold_data = '0;
  int           ir_drops = 0;

  // Snapshots taken at the sampling edge of the most recent step.
  logic         s_ov, s_ir, s2_ov, s2_ir;
  logic [W-1:0] s_dout, s2_dout;
`ifdef MUX_TREE_SEL_CHECK_EN
  logic         s2_err;
`endif

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_word(input logic [SW-1:0] s);
    if (int'(s) >= N) return '0;
    return din[int'(s)*W +: W];
  endfunction

  // One clock cycle: sample on the falling edge, score, then advance past the rising edge.
  task automatic step();
    logic [W-1:0] w;
    int           a;
    @(negedge clk);
    s_ov    = ov;
    s_ir    = ir;
    s_dout  = dout;
    s2_ov   = ov2;
    s2_ir   = ir2;
    s2_dout = dout2;
`ifdef MUX_TREE_SEL_CHECK_EN
    s2_err  = err2;
`endif
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      hold_prev = 1'b0;
    end else begin
      // Ready whenever some stage is empty or the output is being taken.
      chk("in_ready", 64'(ir), 64'((exp_q.size() < LAT) || ordy));
      if (!ir) ir_drops++;
      if (hold_prev) begin
        chk("hold_valid", 64'(ov), 64'(1));
        chk("hold_data", dout, hold_data);
      end
      if (ov && ordy) begin
        if (exp_q.size() == 0) begin
          chk("out_when_empty", 64'(ov), 64'(0));
        end else begin
          w = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("data_out", dout, w);
          last_got = dout;
          last_lat = cyc - a;
          got_n++;
          if (chk_lat) chk("latency", 64'(last_lat), 64'(LAT));
        end
      end
`ifdef MUX_TREE_SEL_CHECK_EN
      if (ov) chk("sel_err_pow2", 64'(err1), 64'(0));
`endif
      hold_prev = ov && !ordy;
      hold_data = dout;
      if (iv && ir) begin
        exp_q.push_back(ref_word(sel));
        acc_q.push_back(cyc);
        acc_n++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_got;
    int base_acc;
    int t4[4];
    int idx;
    t4 = '{5, 6, 7, 8};

    rst_n = 1'b0;
    iv    = 1'b1;
    ordy  = 1'b0;
    sel   = SW'(9);
    iv2   = 1'b0;
    sel2  = '0;
    for (int i = 0; i < N; i++)  din[i*W +: W]  = 64'hA5A5_0000_0000_0000 + 64'(i);
    for (int i = 0; i < N2; i++) din2[i*W +: W] = 64'h5A5A_0000_0000_0000 + 64'(i);
    @(posedge clk);
    #1;

    // T1: reset held two cycles with in_valid high
    step();
    step();
    rst_n = 1'b1;
    iv    = 1'b0;
    step();
    chk("t1_out_valid", 64'(s_ov), 64'(0));
    chk("t1_data_out", s_dout, 64'(0));
    chk("t1_in_ready", 64'(s_ir), 64'(1));
    chk("t1_dut24_out_valid", 64'(s2_ov), 64'(0));

    // T2: single word, fixed latency
    chk_lat  = 1'b1;
    ordy     = 1'b1;
    base_got = got_n;
    iv       = 1'b1;
    sel      = SW'(17);
    step();
    iv = 1'b0;
    repeat (LAT) step();
    chk("t2_count", 64'(got_n - base_got), 64'(1));
    chk("t2_word", last_got, 64'hA5A5_0000_0000_0011);
    chk("t2_latency", 64'(last_lat), 64'(LAT));

    // T3: back-to-back streaming
    base_got = got_n;
    ir_drops = 0;
    foreach (t4[i]) begin
      sel = (i == 0) ? SW'(0) : (i == 1) ? SW'(31) : (i == 2) ? SW'(16) : SW'(1);
      iv  = 1'b1;
      step();
    end
    iv = 1'b0;
    repeat (LAT + 1) step();
    chk("t3_count", 64'(got_n - base_got), 64'(4));
    chk("t3_last_word", last_got, 64'hA5A5_0000_0000_0001);
    chk("t3_in_ready_held", 64'(ir_drops), 64'(0));
    chk_lat = 1'b0;

    // T4: backpressure fills the pipe, then drains without loss
    ordy     = 1'b0;
    base_acc = acc_n;
    base_got = got_n;
    iv       = 1'b1;
    repeat (6) begin
      idx = acc_n - base_acc;
      sel = SW'(t4[(idx > 3) ? 3 : idx]);
      step();
    end
    chk("t4_accepted", 64'(acc_n - base_acc), 64'(3));
    chk("t4_in_ready", 64'(s_ir), 64'(0));
    chk("t4_out_valid", 64'(s_ov), 64'(1));
    chk("t4_frozen", s_dout, 64'hA5A5_0000_0000_0005);
    ordy = 1'b1;
    for (int n = 0; n < 20 && (acc_n - base_acc) < 4; n++) begin
      sel = SW'(t4[acc_n - base_acc]);
      step();
    end
    iv = 1'b0;
    repeat (LAT + 2) step();
    chk("t4_accepted_all", 64'(acc_n - base_acc), 64'(4));
    chk("t4_delivered", 64'(got_n - base_got), 64'(4));
    chk("t4_last_word", last_got, 64'hA5A5_0000_0000_0008);

    // T5: reset with two words in flight drops both
    base_got = got_n;
    iv  = 1'b1;
    sel = SW'(3);
    step();
    sel = SW'(4);
    step();
    iv    = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t5_out_valid", 64'(s_ov), 64'(0));
    chk("t5_data_out", s_dout, 64'(0));
    repeat (5) step();
    chk("t5_none_delivered", 64'(got_n - base_got), 64'(0));

    // T6: 24-input instance, in-range and out-of-range select
    iv2  = 1'b1;
    sel2 = SW'(23);
    step();
    chk("t6_in_ready", 64'(s2_ir), 64'(1));
    sel2 = SW'(27);
    step();
    iv2 = 1'b0;
    step();
    step();
    chk("t6_valid_23", 64'(s2_ov), 64'(1));
    chk("t6_word_23", s2_dout, 64'h5A5A_0000_0000_0017);
`ifdef MUX_TREE_SEL_CHECK_EN
    chk("t6_err_23", 64'(s2_err), 64'(0));
`endif
    step();
    chk("t6_valid_27", 64'(s2_ov), 64'(1));
    chk("t6_word_27", s2_dout, 64'(0));
`ifdef MUX_TREE_SEL_CHECK_EN
    chk("t6_err_27", 64'(s2_err), 64'(1));
`endif
    step();
    chk("t6_drained", 64'(s2_ov), 64'(0));

    // Randomized traffic with random stalls and changing data
    base_got = got_n;
    base_acc = acc_n;
    for (int n = 0; n < 400; n++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 9) < 7);
      sel  = SW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N; i++) din[i*W +: W] = {$urandom, $urandom};
      end
      step();
    end
    iv   = 1'b0;
    ordy = 1'b1;
    repeat (LAT + 2) step();
    chk("rand_drain", 64'(got_n - base_got), 64'(acc_n - base_acc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
